// File: rtl/label_rom_scheduler.sv
// label_rom_scheduler: shares one synchronous image-ROM port between the
// score label (0) and the hi-score digits (1). Three-stage pixel pipeline:
// hit test + address, ROM access, transparent-key output. Label 1 can blink
// under a frame-synchronous FSM. Enables are shadowed at frame_start so
// mid-frame changes never tear the picture.
module label_rom_scheduler #(
  parameter int BITS_PER_COLOR = 12,
  parameter int ADDR_W         = 16,
  parameter int L0_X           = 195,
  parameter int L0_Y           = 60,
  parameter int L0_W           = 249,
  parameter int L0_H           = 246,
  parameter int L1_X           = 260,
  parameter int L1_Y           = 320,
  parameter int L1_W           = 120,
  parameter int L1_H           = 40,
  parameter logic [BITS_PER_COLOR-1:0] TRANSPARENT = 12'hF0F,
  parameter int BLINK_FRAMES   = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                x,
  input  logic [8:0]                y,
  input  logic                      frame_start,
  input  logic [1:0]                label_en,
  input  logic                      blink_en,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_sel,
  input  logic [BITS_PER_COLOR-1:0] rom_data,
  output logic                      inside_label,
  output logic                      label_id,
  output logic [BITS_PER_COLOR-1:0] pixel_data
);

  localparam logic [31:0] L0_X32 = 32'(L0_X);
  localparam logic [31:0] L0_Y32 = 32'(L0_Y);
  localparam logic [31:0] L0_W32 = 32'(L0_W);
  localparam logic [31:0] L0_H32 = 32'(L0_H);
  localparam logic [31:0] L1_X32 = 32'(L1_X);
  localparam logic [31:0] L1_Y32 = 32'(L1_Y);
  localparam logic [31:0] L1_W32 = 32'(L1_W);
  localparam logic [31:0] L1_H32 = 32'(L1_H);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {ST_VISIBLE = 1'b0, ST_HIDDEN = 1'b1} blink_state_t;

  blink_state_t        state_r, state_nx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
  logic [1:0]          en_sh_r;
  logic                blink_sh_r;
  logic [31:0]         x_ext_s, y_ext_s;
  logic [31:0]         addr0_full_s, addr1_full_s;
  logic                hit0_s, hit1_s;
  logic                hit_nx_s, id_nx_s, sel_nx_s;
  logic [ADDR_W-1:0]   addr_nx_s;
  logic                hit_r, id_r, hit_d_r, id_d_r;

  // Region hit test with visibility gating, fixed priority and address select.
  always_comb begin
    x_ext_s      = {22'd0, x};
    y_ext_s      = {23'd0, y};
    addr0_full_s = (x_ext_s - L0_X32) + L0_W32 * (y_ext_s - L0_Y32);
    addr1_full_s = (x_ext_s - L1_X32) + L1_W32 * (y_ext_s - L1_Y32);
    hit0_s = en_sh_r[0] &&
             (x_ext_s >= L0_X32) && (x_ext_s < L0_X32 + L0_W32) &&
             (y_ext_s >= L0_Y32) && (y_ext_s < L0_Y32 + L0_H32);
    hit1_s = en_sh_r[1] && (state_r == ST_VISIBLE) &&
             (x_ext_s >= L1_X32) && (x_ext_s < L1_X32 + L1_W32) &&
             (y_ext_s >= L1_Y32) && (y_ext_s < L1_Y32 + L1_H32);
    hit_nx_s  = hit0_s || hit1_s;
    id_nx_s   = 1'b0;
    sel_nx_s  = rom_sel;
    addr_nx_s = rom_addr;
    if (hit0_s) begin
      sel_nx_s  = 1'b0;
      addr_nx_s = addr0_full_s[ADDR_W-1:0];
    end else if (hit1_s) begin
      id_nx_s   = 1'b1;
      sel_nx_s  = 1'b1;
      addr_nx_s = addr1_full_s[ADDR_W-1:0];
    end else begin
      sel_nx_s  = rom_sel;
      addr_nx_s = rom_addr;
    end
  end

  // Blink next-state: only advances on frame_start; dropping blink forces VISIBLE.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    if (frame_start) begin
      if (!blink_sh_r || !blink_en) begin
        state_nx_s = ST_VISIBLE;
        cnt_nx_s   = {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_nx_s = {CNT_W{1'b0}};
        case (state_r)
          ST_VISIBLE: state_nx_s = ST_HIDDEN;
          ST_HIDDEN:  state_nx_s = ST_VISIBLE;
          default:    state_nx_s = ST_VISIBLE;
        endcase
      end else begin
        cnt_nx_s = cnt_r + CNT_W'(1);
      end
    end else begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
    end
  end

  // Blink state register and frame-synchronous enable shadows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_VISIBLE;
      cnt_r      <= {CNT_W{1'b0}};
      en_sh_r    <= 2'b00;
      blink_sh_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      if (frame_start) begin
        en_sh_r    <= label_en;
        blink_sh_r <= blink_en;
      end
    end
  end

  // Stage 1 and 2: ROM request registers, then hit/id delayed to meet rom_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= {ADDR_W{1'b0}};
      rom_sel  <= 1'b0;
      hit_r    <= 1'b0;
      id_r     <= 1'b0;
      hit_d_r  <= 1'b0;
      id_d_r   <= 1'b0;
    end else begin
      rom_addr <= addr_nx_s;
      rom_sel  <= sel_nx_s;
      hit_r    <= hit_nx_s;
      id_r     <= id_nx_s;
      hit_d_r  <= hit_r;
      id_d_r   <= id_r;
    end
  end

  // Stage 3: transparent-key test and registered colour outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inside_label <= 1'b0;
      label_id     <= 1'b0;
      pixel_data   <= {BITS_PER_COLOR{1'b0}};
    end else begin
      inside_label <= hit_d_r && (rom_data != TRANSPARENT);
      label_id     <= id_d_r;
      pixel_data   <= (hit_d_r && (rom_data != TRANSPARENT)) ? rom_data
                                                             : {BITS_PER_COLOR{1'b0}};
    end
  end

endmodule

// File: tb/tb_label_rom_scheduler.sv
// Bench for label_rom_scheduler: directed scenarios plus random pixels, all
// checked each cycle against a behavioural model built from frame counts and
// rectangle arithmetic, with a few literal pins on known pixels.
module tb_label_rom_scheduler;

  typedef struct {
    logic        hit;
    logic        id;
    logic        sel;
    logic [15:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_start;
  logic [1:0]  label_en;
  logic        blink_en;
  logic [15:0] rom_addr, o_rom_addr;
  logic        rom_sel, o_rom_sel;
  logic [11:0] rom_data, o_rom_data;
  logic        inside_label, o_inside_label;
  logic        label_id, o_label_id;
  logic [11:0] pixel_data, o_pixel_data;

  int total = 0;
  int bad   = 0;

  // model state
  int          c = 0;
  logic [1:0]  m_en = 2'b00;
  logic        m_blink = 1'b0;
  logic [15:0] m_addr = 16'd0;
  logic        m_sel = 1'b0;
  ent_t        p0, p1, p2;
  logic        exp_valid = 1'b0;
  int          exp_addr = 0, exp_pix = 0;
  logic        exp_sel = 1'b0, exp_hit = 1'b0, exp_inside = 1'b0, exp_id = 1'b0;

  always #5 clk = ~clk;

  label_rom_scheduler u_dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .label_en(label_en), .blink_en(blink_en), .rom_addr(rom_addr),
    .rom_sel(rom_sel), .rom_data(rom_data), .inside_label(inside_label),
    .label_id(label_id), .pixel_data(pixel_data)
  );

  label_rom_scheduler #(.L1_Y(60)) u_ovl (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .label_en(label_en), .blink_en(blink_en), .rom_addr(o_rom_addr),
    .rom_sel(o_rom_sel), .rom_data(o_rom_data), .inside_label(o_inside_label),
    .label_id(o_label_id), .pixel_data(o_pixel_data)
  );

  function automatic logic [11:0] rom_fn(input logic sel, input logic [15:0] addr);
    int          v;
    logic [11:0] r;
    if (addr % 16'd17 == 16'd3) return 12'hF0F;
    if (!sel && addr == 16'd0) return 12'h123;
    v = int'(addr) * 37 + (sel ? 1000 : 0) + 5;
    r = v[11:0];
    if (r == 12'hF0F) r = 12'h0F0;
    return r;
  endfunction

  // Synchronous ROM models: data valid one clock after the address.
  always @(posedge clk) begin
    rom_data   <= rom_fn(rom_sel, rom_addr);
    o_rom_data <= rom_fn(o_rom_sel, o_rom_addr);
  end

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("rom_addr", int'(rom_addr), exp_addr);
      chk("rom_sel", int'(rom_sel), int'(exp_sel));
      chk("inside_label", int'(inside_label), int'(exp_inside));
      chk("pixel_data", int'(pixel_data), exp_pix);
      if (exp_hit) chk("label_id", int'(label_id), int'(exp_id));
    end
  end

  task automatic clear_model();
    ent_t z;
    z.hit = 1'b0; z.id = 1'b0; z.sel = 1'b0; z.addr = 16'd0;
    p0 = z; p1 = z; p2 = z;
    c = 0; m_en = 2'b00; m_blink = 1'b0; m_addr = 16'd0; m_sel = 1'b0;
    exp_addr = 0; exp_sel = 1'b0; exp_hit = 1'b0; exp_inside = 1'b0;
    exp_id = 1'b0; exp_pix = 0;
  endtask

  task automatic tick(input int xi, input int yi, input logic fs);
    logic        vis1, in0, in1, h0, h1;
    ent_t        e;
    logic [11:0] d;
    x = 10'(xi); y = 9'(yi); frame_start = fs;
    vis1 = ((c / 30) % 2) == 0;
    in0 = (xi >= 195) && (xi < 444) && (yi >= 60) && (yi < 306);
    in1 = (xi >= 260) && (xi < 380) && (yi >= 320) && (yi < 360);
    h0 = m_en[0] && in0;
    h1 = m_en[1] && vis1 && in1;
    e.hit = h0 || h1;
    e.id = 1'b0;
    if (h0) begin
      m_addr = 16'((xi - 195) + 249 * (yi - 60)); m_sel = 1'b0;
    end else if (h1) begin
      m_addr = 16'((xi - 260) + 120 * (yi - 320)); m_sel = 1'b1; e.id = 1'b1;
    end
    e.sel = m_sel; e.addr = m_addr;
    if (fs) begin
      c = (m_blink && blink_en) ? c + 1 : 0;
      m_en = label_en; m_blink = blink_en;
    end
    @(posedge clk); #1;
    p2 = p1; p1 = p0; p0 = e;
    d = rom_fn(p2.sel, p2.addr);
    exp_addr = int'(m_addr); exp_sel = m_sel; exp_hit = p2.hit; exp_id = p2.id;
    exp_inside = p2.hit && (d != 12'hF0F);
    exp_pix = exp_inside ? int'(d) : 0;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_inside", int'(inside_label), 0);
    chk("rst_pixel", int'(pixel_data), 0);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_sel", int'(rom_sel), 0);
    chk("rst_id", int'(label_id), 0);
    clear_model();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; x = 10'd0; y = 9'd0; frame_start = 1'b0;
    label_en = 2'b00; blink_en = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    exp_valid = 1'b1;

    // 1: nothing visible before the first frame_start
    repeat (3) tick(195, 60, 1'b0);
    chk("pre_fs_inside", int'(inside_label), 0);
    label_en = 2'b01;
    tick(0, 0, 1'b1);
    tick(195, 60, 1'b0);
    chk("t1_addr", int'(rom_addr), 0);
    chk("t1_sel", int'(rom_sel), 0);
    // 2: label 0 addressing and bounds
    tick(196, 61, 1'b0);
    chk("t2_addr250", int'(rom_addr), 250);
    tick(443, 305, 1'b0);
    chk("t2_addr61253", int'(rom_addr), 61253);
    chk("t1_inside", int'(inside_label), 1);
    chk("t1_pixel", int'(pixel_data), 12'h123);
    chk("t1_id", int'(label_id), 0);
    tick(444, 60, 1'b0);
    tick(195, 306, 1'b0);
    tick(0, 0, 1'b0);
    chk("t2_right_edge", int'(inside_label), 0);
    tick(0, 0, 1'b0);
    chk("t2_bottom_edge", int'(pixel_data), 0);

    // 3: label 1
    label_en = 2'b10;
    tick(0, 0, 1'b1);
    tick(260, 320, 1'b0);
    chk("t3_sel", int'(rom_sel), 1);
    chk("t3_addr0", int'(rom_addr), 0);
    tick(379, 359, 1'b0);
    chk("t3_addr4799", int'(rom_addr), 4799);
    tick(0, 0, 1'b0);
    tick(0, 0, 1'b0);
    chk("t3_id", int'(label_id), 1);
    chk("t3_inside", int'(inside_label), 1);
    label_en = 2'b11;
    tick(0, 0, 1'b1);
    tick(260, 60, 1'b0);
    chk("ovl_sel", int'(o_rom_sel), 0);
    tick(0, 0, 1'b0);
    tick(0, 0, 1'b0);
    chk("ovl_id", int'(o_label_id), 0);
    chk("ovl_inside", int'(o_inside_label), 1);

    // 4: transparency and streaming
    tick(198, 60, 1'b0);
    tick(0, 0, 1'b0);
    tick(0, 0, 1'b0);
    chk("t4_transp_inside", int'(inside_label), 0);
    chk("t4_transp_pixel", int'(pixel_data), 0);
    for (int i = 195; i <= 205; i++) tick(i, 100, 1'b0);
    tick(0, 0, 1'b0);
    tick(0, 0, 1'b0);

    // 5: blink of label 1
    label_en = 2'b10; blink_en = 1'b1;
    for (int f = 1; f <= 91; f++) begin
      tick(0, 0, 1'b1);
      tick(379, 359, 1'b0);
      tick(0, 0, 1'b0);
      tick(0, 0, 1'b0);
      if (f == 30) chk("blink_f30", int'(inside_label), 1);
      if (f == 31) chk("blink_f31", int'(inside_label), 0);
      if (f == 61) chk("blink_f61", int'(inside_label), 1);
    end
    blink_en = 1'b0;
    tick(379, 359, 1'b0);
    tick(0, 0, 1'b0);
    tick(0, 0, 1'b0);
    chk("blink_drop_hold", int'(inside_label), 0);
    tick(0, 0, 1'b1);
    tick(379, 359, 1'b0);
    tick(0, 0, 1'b0);
    tick(0, 0, 1'b0);
    chk("blink_drop_vis", int'(inside_label), 1);

    // 6: reset mid-stream
    label_en = 2'b01;
    tick(0, 0, 1'b1);
    repeat (3) tick(201, 100, 1'b0);
    chk("t6_before", int'(inside_label), 1);
    do_reset();
    repeat (3) tick(201, 100, 1'b0);
    chk("t6_after", int'(inside_label), 0);
    tick(0, 0, 1'b1);
    repeat (3) tick(201, 100, 1'b0);
    chk("t6_refs", int'(inside_label), 1);

    // random traffic
    label_en = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) label_en = 2'($urandom_range(0, 3));
      blink_en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 799) == 0) do_reset();
      tick(int'($urandom_range(180, 460)), int'($urandom_range(40, 380)),
           $urandom_range(0, 7) == 0);
    end
    tick(0, 0, 1'b0);
    tick(0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/label_rom_scheduler.md
Name: label_rom_scheduler

Overview:
- Pixel-pipeline controller that shares one synchronous image-ROM read port between two screen labels: label 0 is the score label and label 1 is the hi-score digits.
- Per pixel it:
  - does the region hit test with fixed priority,
  - computes the bank select and ROM address,
  - aligns the hit flag with the returned ROM data,
  - applies a transparent-colour key.
- A frame-synchronous blink FSM flashes label 1.
- Sits between the VGA timing generator (x, y, frame_start) and the colour mux.

Parameters:
- BITS_PER_COLOR, 12, width of colour words.
- ADDR_W, 16, ROM address width. Must hold max(L0_W*L0_H, L1_W*L1_H).
- L0_X, 195, label 0 left column.
- L0_Y, 60, label 0 top row.
- L0_W, 249, label 0 width in pixels.
- L0_H, 246, label 0 height in pixels.
- L1_X, 260, label 1 left column.
- L1_Y, 320, label 1 top row.
- L1_W, 120, label 1 width.
- L1_H, 40, label 1 height.
- TRANSPARENT, 12'hF0F, colour key treated as "not inside".
- BLINK_FRAMES, 30, frames per blink phase. Must be ≥1.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- x  in  10  current pixel column.
- y  in  9  current pixel row.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- label_en  in  2  per-label enable request. Bit 0 = label 0.
- blink_en  in  1  request blinking of label 1.
- rom_addr  out  ADDR_W  registered ROM read address.
- rom_sel  out  1  registered ROM bank select: 0 = label 0 image, 1 = label 1 image.
- rom_data  in  BITS_PER_COLOR  ROM output. Valid one clock after rom_addr/rom_sel.
- inside_label  out  1  registered: pixel belongs to a visible, non-transparent label.
- label_id  out  1  registered: which label owns the pixel.
- pixel_data  out  BITS_PER_COLOR  registered colour. Zero when inside_label=0.

Behaviour:
- Reset (asynchronous, active-high):
  - All pipeline registers and outputs go to 0: rom_addr=0, rom_sel=0, inside_label=0, label_id=0, pixel_data=0.
  - Enable shadow = 2'b00; blink_en shadow = 0.
  - Blink FSM = VISIBLE; frame counter = 0.
  - Consequence: nothing is displayed until the first frame_start after reset.
- Region test, on x/y sampled at edge k:
  - Label n is hit when L*_X ≤ x < L*_X+L*_W and L*_Y ≤ y < L*_Y+L*_H.
  - Bounds are half-open; the right and bottom edges are excluded.
- Visibility:
  - Label 0 visible = shadow_en[0].
  - Label 1 visible = shadow_en[1] AND state==VISIBLE.
- Arbitration: if both visible labels are hit, label 0 wins (fixed priority).
- Address: (x − X) + W·(y − Y) for the winning label, computed at full width and truncated to ADDR_W. If no label is hit, rom_addr holds its previous value.
- Pipeline stage 1 (edge k) registers: rom_addr, rom_sel, hit, id.
- Pipeline stage 2 (edge k+1): ROM produces rom_data; hit and id are delayed one stage.
- Pipeline stage 3 (edge k+2):
  - inside_label = hit_d AND (rom_data ≠ TRANSPARENT).
  - pixel_data = rom_data when inside, else 0.
  - label_id = id_d.
- Latency: exactly 2 clocks from the sample edge to the outputs. Continuous throughput of 1 pixel/clock, with no bubbles.
- Shadow registers:
  - label_en and blink_en are captured into shadows only on a clock with frame_start=1.
  - Changes mid-frame therefore never tear the image.
- Blink FSM, evaluated only on clocks where frame_start=1:
  - If shadowed blink_en=0, or blink_en=0 at this frame_start: state ← VISIBLE, counter ← 0.
  - Else if counter == BLINK_FRAMES−1: toggle VISIBLE↔HIDDEN, counter ← 0.
  - Else: counter ← counter + 1.
  - The blink FSM affects label 1 only.
- x/y outside the screen need no special handling; the region test alone decides.
- Reset asserted mid-frame clears the pipeline immediately. Outputs are 0 from the reset edge onward, including any pixels still in flight.

Test Plan:
1. Reset, then present x=195, y=60 without frame_start → inside_label stays 0 for all cycles. Then pulse frame_start with label_en=01 and present the same pixel → rom_sel=0 and rom_addr=0 after edge k; with rom_data=12'h123 the outputs after edge k+2 are inside_label=1, pixel_data=12'h123, label_id=0.
2. Label 0 addressing and bounds:
   - x=196, y=61 → rom_addr=250.
   - x=443, y=305 → rom_addr=61253.
   - x=444, y=60 and x=195, y=306 → inside_label=0, pixel_data=0.
3. Label 1 with label_en=10, both after frame_start:
   - x=260, y=320 → rom_sel=1, rom_addr=0.
   - x=379, y=359 → rom_addr=4799, label_id=1.
   - Overlap case: with parameters overridden so L1_Y=60, the pixel x=260, y=60 yields rom_sel=0, label_id=0.
4. Transparency and throughput:
   - Inside pixel with rom_data=12'hF0F → inside_label=0, pixel_data=0.
   - Streaming x=195..205 on consecutive clocks → outputs track the inputs 2 cycles later with no gaps.
5. Blink, with BLINK_FRAMES=30 and blink_en=1 sampled at frame_start:
   - Label 1 is HIDDEN after the 31st frame_start and VISIBLE again after the 61st.
   - Dropping blink_en mid-frame keeps the current state until the next frame_start, which forces VISIBLE.
6. Reset pulsed mid-stream while inside label 0 → all outputs are 0 asynchronously. Shadows are cleared, so nothing is displayed until the next frame_start.
